// File: rtl/icache_nway_pkg.sv
// Shared instruction-cache package.
//   ifill_state_t : ICHECK (lookup) / IFILL (block refill) for icache_nway.
//   woff_bits/idx_bits/tag_bits : address field widths from SETS/BLKWORDS.
//   field_w       : storage width for a field that may be zero bits wide.
//   icachef_t     : fixed-width frame of the legacy direct-mapped icache.
package icache_nway_pkg;

  typedef enum logic [0:0] {ICHECK, IFILL} ifill_state_t;

  function automatic int unsigned woff_bits(input int unsigned blkwords);
    return $clog2(blkwords);
  endfunction

  function automatic int unsigned idx_bits(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned sets, input int unsigned blkwords);
    return 30 - woff_bits(blkwords) - idx_bits(sets);
  endfunction

  function automatic int unsigned field_w(input int unsigned bits);
    return (bits == 0) ? 1 : bits;
  endfunction

  // Legacy direct-mapped, one-word-per-block cache (16 sets).
  localparam int unsigned ITAG_W = 26;
  localparam int unsigned IIDX_W = 4;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    logic [31:0]       data;
  } icachef_t;

endpackage

// File: rtl/icache_way.sv
// One way of the set-associative icache: valid, tag and data arrays.
//   clk, rst_n          : clock, async active-low reset (clears valid bits)
//   rd_idx/rd_tag/rd_woff -> hit, valid_out, rd_word : combinational lookup
//   wr_en, wr_idx, wr_woff, wr_data : single data-word write
//   tag_wr, wr_tag      : write tag at wr_idx and set its valid bit
//   clear               : invalidate every set (wins over tag_wr)
module icache_way #(
  parameter int unsigned SETS     = 8,
  parameter int unsigned BLKWORDS = 2,
  parameter int unsigned TAG_W    = 26,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned WOFF_W   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [TAG_W-1:0]  rd_tag,
  input  logic [WOFF_W-1:0] rd_woff,
  output logic              hit,
  output logic              valid_out,
  output logic [31:0]       rd_word,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WOFF_W-1:0] wr_woff,
  input  logic [31:0]       wr_data,
  input  logic              tag_wr,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              clear
);

  localparam int unsigned PTR_W = $clog2(SETS * BLKWORDS);

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [31:0]      data [SETS*BLKWORDS];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  assign rd_ptr = PTR_W'(rd_idx) * PTR_W'(BLKWORDS) + PTR_W'(rd_woff);
  assign wr_ptr = PTR_W'(wr_idx) * PTR_W'(BLKWORDS) + PTR_W'(wr_woff);

  assign valid_out = valid[rd_idx];
  assign hit       = valid[rd_idx] && (tags[rd_idx] == rd_tag);
  assign rd_word   = data[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (clear) begin
      valid <= '0;
    end else if (tag_wr) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (tag_wr) tags[wr_idx] <= wr_tag;
    if (wr_en)  data[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/icache_nway.sv
// Parametrised set-associative instruction cache (1 or 2 ways, LRU,
// in-order word-by-word block refill, synchronous full invalidate).
//   CLK, nRST          : clock, async active-low reset
//   imemREN, imemaddr  : fetch request / byte address from the datapath
//   ihit, imemload     : combinational hit and instruction word (0 on no hit)
//   iflush             : invalidate whole cache, aborts an active refill
//   iREN, iaddr        : refill word request / word address to memory
//   iwait, iload       : memory busy / refill data (accepted when !iwait)
module icache_nway
  import icache_nway_pkg::*;
#(
  parameter int unsigned SETS     = 8,
  parameter int unsigned WAYS     = 2,
  parameter int unsigned BLKWORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        iflush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int unsigned WOFF   = woff_bits(BLKWORDS);
  localparam int unsigned IDX    = idx_bits(SETS);
  localparam int unsigned TAG    = tag_bits(SETS, BLKWORDS);
  localparam int unsigned WOFF_W = field_w(WOFF);

  ifill_state_t      state, next_state;
  logic [TAG-1:0]    miss_tag;
  logic [IDX-1:0]    miss_idx;
  logic [WOFF_W-1:0] cnt;
  logic              miss_way;
  logic [SETS-1:0]   lru;

  logic [29:0]       word_addr;
  logic [TAG-1:0]    req_tag;
  logic [IDX-1:0]    req_idx;
  logic [WOFF_W-1:0] req_woff;
  logic              unused_byte_off;

  logic [WAYS-1:0]   way_hit, way_valid, way_wr, way_tag_wr;
  logic [31:0]       way_word [WAYS];

  logic              hit_any, hit_way, victim;
  logic              miss, accept, fill_wr, fill_done;
  logic [31:0]       hit_word;

  // Field extraction by shift/mask so BLKWORDS=1 (zero offset bits) needs no special case.
  assign word_addr       = imemaddr[31:2];
  assign unused_byte_off = ^imemaddr[1:0];
  assign req_woff        = WOFF_W'(word_addr & 30'(BLKWORDS - 1));
  assign req_idx         = IDX'(word_addr >> WOFF);
  assign req_tag         = TAG'(word_addr >> (WOFF + IDX));

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_wr[w]     = fill_wr && (miss_way == 1'(w));
    assign way_tag_wr[w] = fill_done && (miss_way == 1'(w));

    icache_way #(
      .SETS     (SETS),
      .BLKWORDS (BLKWORDS),
      .TAG_W    (TAG),
      .IDX_W    (IDX),
      .WOFF_W   (WOFF_W)
    ) u_way (
      .clk       (CLK),
      .rst_n     (nRST),
      .rd_idx    (req_idx),
      .rd_tag    (req_tag),
      .rd_woff   (req_woff),
      .hit       (way_hit[w]),
      .valid_out (way_valid[w]),
      .rd_word   (way_word[w]),
      .wr_en     (way_wr[w]),
      .wr_idx    (miss_idx),
      .wr_woff   (cnt),
      .wr_data   (iload),
      .tag_wr    (way_tag_wr[w]),
      .wr_tag    (miss_tag),
      .clear     (iflush)
    );
  end

  always_comb begin
    hit_way  = 1'b0;
    hit_word = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        hit_way  = 1'(w);
        hit_word = way_word[w];
      end
    end
  end

  // Lowest invalid way first, otherwise the way the set's LRU bit names.
  always_comb begin
    victim = lru[req_idx];
    if (WAYS == 1)                          victim = 1'b0;
    else if (!way_valid[0])                 victim = 1'b0;
    else if (!way_valid[WAYS-1])            victim = 1'b1;
  end

  always_comb begin
    next_state = state;
    hit_any    = |way_hit;
    ihit       = (state == ICHECK) && imemREN && !iflush && hit_any;
    miss       = (state == ICHECK) && imemREN && !iflush && !hit_any;
    accept     = (state == IFILL) && !iwait;
    fill_wr    = accept && !iflush;
    fill_done  = fill_wr && (cnt == WOFF_W'(BLKWORDS - 1));
    imemload   = ihit ? hit_word : '0;
    iREN       = (state == IFILL);
    iaddr      = '0;
    if (state == IFILL)
      iaddr = (32'(miss_tag) << (2 + WOFF + IDX)) | (32'(miss_idx) << (2 + WOFF)) | (32'(cnt) << 2);

    case (state)
      ICHECK: if (miss) next_state = IFILL;
      IFILL:  if (iflush || fill_done) next_state = ICHECK;
      default: next_state = ICHECK;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= ICHECK;
      cnt      <= '0;
      miss_tag <= '0;
      miss_idx <= '0;
      miss_way <= 1'b0;
      lru      <= '0;
    end else begin
      state <= next_state;
      if (miss) begin
        miss_tag <= req_tag;
        miss_idx <= req_idx;
        miss_way <= victim;
        cnt      <= '0;
      end else if (accept) begin
        cnt <= cnt + 1'b1;
      end

      if (iflush)         lru           <= '0;
      else if (ihit)      lru[req_idx]  <= ~hit_way;
      else if (fill_done) lru[miss_idx] <= ~miss_way;
    end
  end

endmodule

// File: tb/tb_icache_nway.sv
module tb_icache_nway;

  logic        clk = 1'b0;
  logic        rst_s   [2];
  logic        req_s   [2];
  logic [31:0] addr_s  [2];
  logic        flush_s [2];
  logic        iwait_s [2];
  logic        hit_o   [2];
  logic [31:0] load_o  [2];
  logic        iren_o  [2];
  logic [31:0] iaddr_o [2];
  logic [31:0] iload_s [2];

  int tests_run    = 0;
  int tests_failed = 0;

  // Configurations: instance 0 default, instance 1 the parameter sweep.
  int unsigned cfg_sets [2] = '{8, 16};
  int unsigned cfg_ways [2] = '{2, 1};
  int unsigned cfg_blk  [2] = '{2, 4};

  // Reference model: which memory block each way of each set holds.
  bit          m_valid [2][2][16];
  int unsigned m_bn    [2][2][16];
  int          m_lru   [2][16];
  bit          m_fill  [2];
  int unsigned m_fbn   [2];
  int unsigned m_fcnt  [2];
  int          m_fway  [2];
  int          m_fset  [2];
  bit          obs_hit;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  assign iload_s[0] = mem_word(iaddr_o[0]);
  assign iload_s[1] = mem_word(iaddr_o[1]);

  icache_nway #(.SETS(8), .WAYS(2), .BLKWORDS(2)) u_dut0 (
    .CLK(clk), .nRST(rst_s[0]), .imemREN(req_s[0]), .imemaddr(addr_s[0]),
    .ihit(hit_o[0]), .imemload(load_o[0]), .iflush(flush_s[0]), .iREN(iren_o[0]),
    .iaddr(iaddr_o[0]), .iwait(iwait_s[0]), .iload(iload_s[0])
  );

  icache_nway #(.SETS(16), .WAYS(1), .BLKWORDS(4)) u_dut1 (
    .CLK(clk), .nRST(rst_s[1]), .imemREN(req_s[1]), .imemaddr(addr_s[1]),
    .ihit(hit_o[1]), .imemload(load_o[1]), .iflush(flush_s[1]), .iREN(iren_o[1]),
    .iaddr(iaddr_o[1]), .iwait(iwait_s[1]), .iload(iload_s[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int k);
    for (int s = 0; s < 16; s++) begin
      m_lru[k][s] = 0;
      for (int w = 0; w < 2; w++) m_valid[k][w][s] = 1'b0;
    end
    m_fill[k] = 1'b0;
    m_fcnt[k] = 0;
  endtask

  function automatic int other_way(input int k, input int w);
    return (cfg_ways[k] == 2) ? 1 - w : 0;
  endfunction

  // One cycle on instance k: called just after a falling edge, returns after the next one.
  task automatic step(input int k, input bit rq, input logic [31:0] a, input bit fl, input bit stall);
    int unsigned bn, set;
    int hw, vic;
    bit e_hit;
    logic [31:0] e_addr;
    req_s[k] = rq; addr_s[k] = a; flush_s[k] = fl; iwait_s[k] = stall;
    #1;
    bn  = 32'(a[31:2]) / cfg_blk[k];
    set = bn % cfg_sets[k];
    hw  = -1;
    if (!m_fill[k] && rq && !fl)
      for (int w = 0; w < int'(cfg_ways[k]); w++)
        if (m_valid[k][w][set] && m_bn[k][w][set] == bn) hw = w;
    e_hit  = (hw >= 0);
    e_addr = m_fill[k] ? (m_fbn[k] * cfg_blk[k] * 4 + m_fcnt[k] * 4) : 32'h0;
    check("ihit",     32'(hit_o[k]), 32'(e_hit));
    check("imemload", load_o[k], e_hit ? mem_word({a[31:2], 2'b00}) : 32'h0);
    check("iREN",     32'(iren_o[k]), 32'(m_fill[k]));
    check("iaddr",    iaddr_o[k], e_addr);
    obs_hit = hit_o[k];
    @(posedge clk);
    if (fl) begin
      model_reset(k);
    end else if (m_fill[k]) begin
      if (!stall) begin
        m_fcnt[k]++;
        if (m_fcnt[k] == cfg_blk[k]) begin
          m_valid[k][m_fway[k]][m_fset[k]] = 1'b1;
          m_bn[k][m_fway[k]][m_fset[k]]    = m_fbn[k];
          m_lru[k][m_fset[k]]              = other_way(k, m_fway[k]);
          m_fill[k]                        = 1'b0;
        end
      end
    end else if (rq) begin
      if (hw >= 0) begin
        m_lru[k][set] = other_way(k, hw);
      end else begin
        vic = -1;
        for (int w = 0; w < int'(cfg_ways[k]); w++)
          if (!m_valid[k][w][set] && vic < 0) vic = w;
        if (vic < 0) vic = m_lru[k][set];
        m_fill[k] = 1'b1; m_fbn[k] = bn; m_fset[k] = int'(set);
        m_fway[k] = vic;  m_fcnt[k] = 0;
      end
    end
    @(negedge clk);
  endtask

  // Fetch a until the DUT reports a hit; lat = cycles from request to hit, -1 on timeout.
  task automatic fetch(input int k, input logic [31:0] a, input int nstall, output int lat);
    int stalls = 0;
    bit st;
    lat = -1;
    for (int c = 0; c < 200; c++) begin
      st = 1'b0;
      if (m_fill[k]) begin
        st = (stalls < nstall);
        stalls = st ? stalls + 1 : 0;
      end
      step(k, 1'b1, a, 1'b0, st);
      if (obs_hit) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic fetch_lat(input int k, input string tag, input logic [31:0] a,
                           input int nstall, input int exp_lat);
    int lat;
    fetch(k, a, nstall, lat);
    check(tag, 32'(lat), 32'(exp_lat));
  endtask

  task automatic reset_mid(input int k);
    rst_s[k] = 1'b0;
    #1;
    check("rst_iren",  32'(iren_o[k]), 32'h0);
    check("rst_ihit",  32'(hit_o[k]),  32'h0);
    check("rst_iaddr", iaddr_o[k],     32'h0);
    model_reset(k);
    @(posedge clk);
    @(negedge clk);
    rst_s[k] = 1'b1;
  endtask

  task automatic random_run(input int k, input int cycles);
    logic [31:0] a;
    for (int i = 0; i < cycles; i++) begin
      a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 7)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = a | 32'hF000_0000;
      step(k, $urandom_range(0, 9) < 8, a, $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 3);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_s[k] = 1'b0; req_s[k] = 1'b0; addr_s[k] = '0;
      flush_s[k] = 1'b0; iwait_s[k] = 1'b0;
      model_reset(k);
    end
    #2;
    for (int k = 0; k < 2; k++) begin
      check("reset_ihit",  32'(hit_o[k]),  32'h0);
      check("reset_iren",  32'(iren_o[k]), 32'h0);
      check("reset_iaddr", iaddr_o[k],     32'h0);
      check("reset_load",  load_o[k],      32'h0);
    end
    @(negedge clk);
    rst_s[0] = 1'b1; rst_s[1] = 1'b1;

    // Cold miss then hit, and the neighbouring word of the same block.
    fetch_lat(0, "cold_miss_lat", 32'h100, 0, 3);
    fetch_lat(0, "same_blk_hit",  32'h104, 0, 0);

    // Two-way conflict in set 0 with LRU eviction.
    fetch_lat(0, "fill_000",   32'h000, 0, 3);
    fetch_lat(0, "fill_040",   32'h040, 0, 3);
    fetch_lat(0, "hit_000",    32'h000, 0, 0);
    fetch_lat(0, "hit_040",    32'h040, 0, 0);
    fetch_lat(0, "touch_000",  32'h000, 0, 0);
    fetch_lat(0, "evict_080",  32'h080, 0, 3);
    fetch_lat(0, "kept_000",   32'h000, 0, 0);
    fetch_lat(0, "evicted_040", 32'h040, 0, 3);

    // Memory wait: three stall cycles before each word.
    fetch_lat(0, "wait_lat", 32'h208, 3, 9);

    // Flush on the first accepted word aborts the fill.
    step(0, 1'b1, 32'h300, 1'b0, 1'b0);
    step(0, 1'b1, 32'h300, 1'b1, 1'b0);
    check("flush_iren", 32'(iren_o[0]), 32'h0);
    fetch_lat(0, "refetch_300", 32'h300, 0, 3);
    fetch_lat(0, "flushed_000", 32'h000, 0, 3);

    // Reset in the middle of a fill.
    step(0, 1'b1, 32'h500, 1'b0, 1'b0);
    step(0, 1'b1, 32'h500, 1'b0, 1'b0);
    reset_mid(0);
    fetch_lat(0, "post_rst_000", 32'h000, 0, 3);
    fetch_lat(0, "post_rst_300", 32'h300, 0, 3);

    random_run(0, 400);
    step(0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Single way, four-word blocks, sixteen sets.
    fetch_lat(1, "sw_cold_lat",  32'h100, 0, 5);
    fetch_lat(1, "sw_word3_hit", 32'h10C, 0, 0);
    fetch_lat(1, "sw_conf_000",  32'h000, 0, 5);
    fetch_lat(1, "sw_conf_100",  32'h100, 0, 5);
    fetch_lat(1, "sw_conf_000b", 32'h000, 0, 5);
    fetch_lat(1, "sw_wait_lat",  32'h040, 1, 9);
    step(1, 1'b1, 32'h0C0, 1'b0, 1'b0);
    step(1, 1'b1, 32'h0C0, 1'b0, 1'b0);
    reset_mid(1);
    fetch_lat(1, "sw_post_rst", 32'h000, 0, 5);

    random_run(1, 400);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
